// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the MEM-stage data-memory responder:
// FSM encoding, byte-lane constants and the legal latency window.
package dmem_defs;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } stateT;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 15;

    function automatic bit latencyValid(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

    // Byte-write-enable for a single-lane store.
    function automatic logic [1:0] laneEnable(input logic lane);
        return (lane == LANE_HI) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 16-bit RAM with per-byte write enables and a
// registered read port; the read returns the pre-write contents.
module dmem_array #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [1:0]        be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [15:0]       wd,
    output logic [15:0]       q
);

    logic [15:0] mem [2**ADDR_W];

    // NOTE: no reset on the storage or read register, so this maps onto a RAM
    // macro; downstream logic masks q until it holds a completed read.
    always_ff @(posedge clk) begin
        if (en) begin
            if (be[0]) mem[idx][7:0]  <= wd[7:0];
            if (be[1]) mem[idx][15:8] <= wd[15:8];
            q <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: captures a load/store, stalls the pipeline
// for LATENCY cycles, then pulses done with steered load data or misalign.
module dmem_responder
    import dmem_defs::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic        req_byte,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam bit         SINGLE_CYCLE = (LATENCY <= 1);
    localparam logic [3:0] CNT_RELOAD   =
        (latencyValid(LATENCY) && LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    stateT             state;
    logic [3:0]        cnt;
    logic              capWrite, capRead, capByte, capLane;
    logic [ADDR_W-1:0] capIdx;
    logic [15:0]       capWdata;
    logic              doneReg, misReg, readReg;

    logic              curWrite, curRead, curByte, curLane, curMis;
    logic [ADDR_W-1:0] curIdx;
    logic [15:0]       curWdata;
    logic              request, access;
    logic [1:0]        memBe;
    logic [15:0]       memWd, memQ;

    logic unusedAddrHi;
    assign unusedAddrHi = ^addr[15:ADDR_W+1];

    assign request = req_rd | req_wr;

    // In IDLE the access may complete at this very edge (LATENCY=1), so the
    // live inputs feed the array; afterwards the captured copy does.
    always_comb begin
        curWrite = capWrite;
        curRead  = capRead;
        curByte  = capByte;
        curLane  = capLane;
        curIdx   = capIdx;
        curWdata = capWdata;
        if (state == IDLE) begin
            curWrite = req_wr;
            curRead  = req_rd & ~req_wr;
            curByte  = req_byte;
            curLane  = addr[0];
            curIdx   = addr[ADDR_W:1];
            curWdata = wdata;
        end
    end

    assign curMis = ~curByte & curLane;

    // Gated by reset so an edge during reset can never commit a store.
    assign access = reset &&
                    ((state == IDLE && request && SINGLE_CYCLE) ||
                     (state == WAIT && cnt == 4'd0));

    assign memBe = (curWrite && !curMis) ? (curByte ? laneEnable(curLane) : 2'b11) : 2'b00;
    assign memWd = curByte ? {curWdata[7:0], curWdata[7:0]} : curWdata;

    dmem_array #(.ADDR_W(ADDR_W)) u_array (
        .clk (clk),
        .en  (access),
        .be  (memBe),
        .idx (curIdx),
        .wd  (memWd),
        .q   (memQ)
    );

    // NOTE: state is updated with non-blocking assignments only, so every
    // branch below sees the pre-edge values of state, cnt and the capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            capWrite <= 1'b0;
            capRead  <= 1'b0;
            capByte  <= 1'b0;
            capLane  <= 1'b0;
            capIdx   <= '0;
            capWdata <= 16'h0000;
            doneReg  <= 1'b0;
            misReg   <= 1'b0;
            readReg  <= 1'b0;
        end else begin
            doneReg <= access;
            misReg  <= access & curMis;
            readReg <= access & curRead & ~curMis;
            case (state)
                IDLE: if (request) begin
                    capWrite <= curWrite;
                    capRead  <= curRead;
                    capByte  <= curByte;
                    capLane  <= curLane;
                    capIdx   <= curIdx;
                    capWdata <= curWdata;
                    if (SINGLE_CYCLE) begin
                        state <= DONE;
                    end else begin
                        state <= WAIT;
                        cnt   <= CNT_RELOAD;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = reset && ((state == IDLE && request) || state == WAIT);
    assign done     = doneReg;
    assign misalign = misReg;
    assign rdata    = !readReg ? 16'h0000 :
                      !capByte ? memQ :
                      (capLane == LANE_HI) ? {8'h00, memQ[15:8]} : {8'h00, memQ[7:0]};

endmodule
